// File: rtl/serv_alu_pkg.sv
// serv_alu_pkg: shared constants and sizing helpers for the serial ALU bridge
package serv_alu_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_ADD  = 3'b001;
    localparam logic [2:0] RD_SLT  = 3'b010;
    localparam logic [2:0] RD_BOOL = 3'b100;

    localparam logic [1:0] BOOL_XOR  = 2'b00;
    localparam logic [1:0] BOOL_ZERO = 2'b01;
    localparam logic [1:0] BOOL_OR   = 2'b10;
    localparam logic [1:0] BOOL_AND  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PREP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int n_beats(input int w);
        return 32 / w;
    endfunction

    function automatic int cnt_width(input int w);
        return (32 / w) > 1 ? $clog2(32 / w) : 1;
    endfunction

endpackage

// File: rtl/serv_alu_bridge_shreg.sv
// serv_alu_bridge_shreg: 32-bit shift register, loads in parallel, shifts right W bits per step
module serv_alu_bridge_shreg #(
    parameter int W  = 1,
    parameter int OW = W
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [31:0]   i_load_data,
    input  logic          i_shift,
    input  logic [W-1:0]  i_data,
    output logic [OW-1:0] o_q
);

    logic [31:0] q;

    // parallel load wins over shift; new serial data enters at the top
    always_ff @(posedge clk) begin
        if (!i_rst_n)
            q <= '0;
        else if (i_load)
            q <= i_load_data;
        else if (i_shift)
            q <= {i_data, q[31:W]};
    end

    assign o_q = q[OW-1:0];

endmodule

// File: rtl/serv_alu_bridge.sv
// serv_alu_bridge: runs the bit-serial ALU as a word-level unit over valid/ready channels
module serv_alu_bridge
    import serv_alu_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [31:0]  i_req_rs1,
    input  logic [31:0]  i_req_op_b,
    input  logic         i_req_sub,
    input  logic [1:0]   i_req_bool_op,
    input  logic         i_req_cmp_eq,
    input  logic         i_req_cmp_sig,
    input  logic [2:0]   i_req_rd_sel,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [31:0]  o_rsp_rd,
    output logic         o_rsp_cmp,
    output logic         o_alu_en,
    output logic         o_alu_cnt0,
    output logic         o_alu_sub,
    output logic [1:0]   o_alu_bool_op,
    output logic         o_alu_cmp_eq,
    output logic         o_alu_cmp_sig,
    output logic [2:0]   o_alu_rd_sel,
    output logic [W-1:0] o_alu_rs1,
    output logic [W-1:0] o_alu_op_b,
    output logic [W-1:0] o_alu_buf,
    input  logic [W-1:0] i_alu_rd,
    input  logic         i_alu_cmp
);

    localparam int N  = n_beats(W);
    localparam int CW = cnt_width(W);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          pass;
    logic [31:0]   rs1_l;
    logic [31:0]   op_b_l;
    logic [2:0]    rd_sel_l;
    logic [W-1:0]  rs1_q;
    logic [W-1:0]  op_b_q;
    logic          run;
    logic          prep;
    logic          last;
    logic          accept;
    logic          slt;

    assign run    = state == ST_RUN;
    assign prep   = state == ST_PREP;
    assign last   = cnt == CW'(N - 1);
    assign accept = i_req_valid && o_req_ready;
    assign slt    = |(rd_sel_l & RD_SLT);

    assign o_req_ready   = state == ST_IDLE;
    assign o_rsp_valid   = state == ST_DONE;
    assign o_alu_en      = run;
    assign o_alu_cnt0    = run && cnt == '0;
    assign o_alu_rd_sel  = slt && !pass ? RD_NONE : rd_sel_l;
    assign o_alu_rs1     = run ? rs1_q : '0;
    assign o_alu_op_b    = run ? op_b_q : '0;
    assign o_alu_buf     = '0;

    serv_alu_bridge_shreg #(.W(W), .OW(W)) u_rs1 (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_load      (accept || prep),
        .i_load_data (prep ? rs1_l : i_req_rs1),
        .i_shift     (run),
        .i_data      ('0),
        .o_q         (rs1_q)
    );

    serv_alu_bridge_shreg #(.W(W), .OW(W)) u_op_b (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_load      (accept || prep),
        .i_load_data (prep ? op_b_l : i_req_op_b),
        .i_shift     (run),
        .i_data      ('0),
        .o_q         (op_b_q)
    );

    // result collects every RUN beat; a second SLT pass overwrites the discarded compare pass
    serv_alu_bridge_shreg #(.W(W), .OW(32)) u_rd (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (run),
        .i_data      (i_alu_rd),
        .o_q         (o_rsp_rd)
    );

    // sequencing: accept, carry-preload cycle, N beats per pass, hold response until taken
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pass          <= 1'b0;
            o_rsp_cmp     <= 1'b0;
            rs1_l         <= '0;
            op_b_l        <= '0;
            rd_sel_l      <= '0;
            o_alu_sub     <= 1'b0;
            o_alu_bool_op <= '0;
            o_alu_cmp_eq  <= 1'b0;
            o_alu_cmp_sig <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (i_req_valid) begin
                    rs1_l         <= i_req_rs1;
                    op_b_l        <= i_req_op_b;
                    rd_sel_l      <= i_req_rd_sel;
                    o_alu_sub     <= i_req_sub;
                    o_alu_bool_op <= i_req_bool_op;
                    o_alu_cmp_eq  <= i_req_cmp_eq;
                    o_alu_cmp_sig <= i_req_cmp_sig;
                    pass          <= 1'b0;
                    state         <= ST_PREP;
                end
                ST_PREP: state <= ST_RUN;
                ST_RUN: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        o_rsp_cmp <= pass ? o_rsp_cmp : i_alu_cmp;
                        pass      <= 1'b1;
                        state     <= slt && !pass ? ST_PREP : ST_DONE;
                    end
                end
                default: state <= i_rsp_ready ? ST_IDLE : ST_DONE;
            endcase
        end
    end

endmodule
